conv2_ctrl: RTL and testbench

CONV2_CTRL -- requirements
Module: conv2_ctrl

---
 rtl/lenet_pkg.sv | 22 ++
 rtl/conv2_addr_gen.sv | 72 +++++++
 rtl/conv2_ctrl.sv | 152 +++++++++++++++
 tb/tb_conv2_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/lenet_pkg.sv
// Shared LeNet geometry, address widths and conv2 FSM encoding.
// CONV2_ADDR_PIPE_EN selects a 3-stage address pipeline; otherwise a single registered stage.
package lenet_pkg;
    localparam int F3_DIM = 14;
    localparam int F4_DIM = 10;
    localparam int K_DIM  = 5;
    localparam int F3_AW  = 11;
    localparam int W_AW   = 8;
    localparam int F4_AW  = 7;
    localparam int CNT_W  = 4;

    localparam logic [3:0] ST_IDLE  = 4'b0001;
    localparam logic [3:0] ST_RUN   = 4'b0010;
    localparam logic [3:0] ST_DRAIN = 4'b0100;
    localparam logic [3:0] ST_DONE  = 4'b1000;

`ifdef CONV2_ADDR_PIPE_EN
    localparam int ADDR_PIPE = 3;
`else
    localparam int ADDR_PIPE = 1;
`endif
endpackage

// File: rtl/conv2_addr_gen.sv
// Turns conv2 tap counters into f3/weight RAM read addresses, ADDR_PIPE cycles later.
// CONV2_ADDR_PIPE_EN: three shift/add stages; otherwise one registered multiply stage. No backpressure.
module conv2_addr_gen
    import lenet_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CNT_W-1:0]     ch,
    input  logic [2:0]           kr,
    input  logic [2:0]           kc,
    input  logic [CNT_W-1:0]     orow,
    input  logic [CNT_W-1:0]     ocol,
    output logic [F3_AW-1:0]     f3_raddr,
    output logic [W_AW-1:0]      w_raddr
);
`ifdef CONV2_ADDR_PIPE_EN
    logic [10:0] ch196_q, ch196_d, f3p_q, f3p_d, f3_q, f3_d;
    logic [7:0]  ch25_q, ch25_d, row14_q, row14_d, w2_q, w2_d, w_q, w_d;
    logic [4:0]  kr5_q, kr5_d;
    logic [3:0]  row_q, row_d, col_q, col_d;
    logic [2:0]  kc1_q, kc1_d;

    // ch*196 = ch*128 + ch*64 + ch*4, ch*25 = ch*16 + ch*8 + ch, row*14 = row*16 - row*2
    always_comb begin
        ch196_d = {ch, 7'b0} + {1'b0, ch, 6'b0} + {5'b0, ch, 2'b0};
        ch25_d  = {ch, 4'b0} + {1'b0, ch, 3'b0} + {4'b0, ch};
        kr5_d   = {kr, 2'b0} + {2'b0, kr};
        kc1_d   = kc;
        row_d   = orow + {1'b0, kr};
        col_d   = ocol + {1'b0, kc};
        f3p_d   = ch196_q + {7'b0, col_q};
        row14_d = {row_q, 4'b0} - {3'b0, row_q, 1'b0};
        w2_d    = ch25_q + {3'b0, kr5_q} + {5'b0, kc1_q};
        f3_d    = f3p_q + {3'b0, row14_q};
        w_d     = w2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ch196_q <= '0; ch25_q <= '0; kr5_q <= '0; kc1_q <= '0;
            row_q   <= '0; col_q  <= '0; f3p_q <= '0; row14_q <= '0;
            w2_q    <= '0; f3_q   <= '0; w_q   <= '0;
        end else begin
            ch196_q <= ch196_d; ch25_q <= ch25_d; kr5_q <= kr5_d; kc1_q <= kc1_d;
            row_q   <= row_d;   col_q  <= col_d;  f3p_q <= f3p_d; row14_q <= row14_d;
            w2_q    <= w2_d;    f3_q   <= f3_d;   w_q   <= w_d;
        end
    end
`else
    logic [F3_AW-1:0] f3_q, f3_d;
    logic [W_AW-1:0]  w_q, w_d;

    always_comb begin
        f3_d = F3_AW'(int'(ch) * F3_DIM * F3_DIM + (int'(orow) + int'(kr)) * F3_DIM
                      + int'(ocol) + int'(kc));
        w_d  = W_AW'(int'(ch) * K_DIM * K_DIM + int'(kr) * K_DIM + int'(kc));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            f3_q <= '0;
            w_q  <= '0;
        end else begin
            f3_q <= f3_d;
            w_q  <= w_d;
        end
    end
`endif

    assign f3_raddr = f3_q;
    assign w_raddr  = w_q;
endmodule

// File: rtl/conv2_ctrl.sv
// Conv2 sequencer: walks 10x10 outputs x IN_CH x 5x5 taps, drives RAM addresses, MAC and f4 writes.
// Address ADDR_PIPE cycles after the tap (3 with CONV2_ADDR_PIPE_EN, else 1), mac_en +RAM_LAT, write +1.
// No backpressure: one tap per RUN cycle; conv2_start is ignored unless IDLE.
module conv2_ctrl
    import lenet_pkg::*;
#(
    parameter int IN_CH   = 6,
    parameter int RAM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              conv2_start,
    output logic [10:0]       f3_raddr,
    output logic [7:0]        w_raddr,
    output logic              mac_clr,
    output logic              mac_en,
    output logic [6:0]        f4_waddr,
    output logic              f4_wr_en,
    output logic              conv2_done,
    output logic              busy
);
    localparam int L = ADDR_PIPE + RAM_LAT;

    logic [3:0]       state_q, state_d;
    logic [2:0]       kc_q, kc_d, kr_q, kr_d;
    logic [CNT_W-1:0] ch_q, ch_d, ocol_q, ocol_d, orow_q, orow_d;
    logic [L-1:0]     vld_q, vld_d, clr_q, clr_d, last_q, last_d;
    logic             wr_q, wr_d;
    logic [F4_AW-1:0] waddr_q, waddr_d, wr_cnt_q, wr_cnt_d;
    logic             run, tap_first, tap_last, final_tap;

    always_comb begin
        state_d  = state_q;
        kc_d     = kc_q;
        kr_d     = kr_q;
        ch_d     = ch_q;
        ocol_d   = ocol_q;
        orow_d   = orow_q;
        waddr_d  = waddr_q;
        wr_cnt_d = wr_cnt_q;

        run       = (state_q == ST_RUN);
        tap_first = (ch_q == '0) && (kr_q == '0) && (kc_q == '0);
        tap_last  = (ch_q == CNT_W'(IN_CH - 1)) && (kr_q == 3'(K_DIM - 1)) && (kc_q == 3'(K_DIM - 1));
        final_tap = tap_last && (ocol_q == CNT_W'(F4_DIM - 1)) && (orow_q == CNT_W'(F4_DIM - 1));

        case (state_q)
            ST_IDLE: if (conv2_start) begin
                state_d  = ST_RUN;
                kc_d     = '0;
                kr_d     = '0;
                ch_d     = '0;
                ocol_d   = '0;
                orow_d   = '0;
                wr_cnt_d = '0;
            end
            ST_RUN:   if (final_tap) state_d = ST_DRAIN;
            ST_DRAIN: if (vld_q == '0) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (run) begin
            if (kc_q == 3'(K_DIM - 1)) begin
                kc_d = '0;
                if (kr_q == 3'(K_DIM - 1)) begin
                    kr_d = '0;
                    if (ch_q == CNT_W'(IN_CH - 1)) begin
                        ch_d = '0;
                        if (ocol_q == CNT_W'(F4_DIM - 1)) begin
                            ocol_d = '0;
                            orow_d = (orow_q == CNT_W'(F4_DIM - 1)) ? '0 : orow_q + 4'd1;
                        end else begin
                            ocol_d = ocol_q + 4'd1;
                        end
                    end else begin
                        ch_d = ch_q + 4'd1;
                    end
                end else begin
                    kr_d = kr_q + 3'd1;
                end
            end else begin
                kc_d = kc_q + 3'd1;
            end
        end

        // Tag pipeline tracks each tap from counter stage to the MAC data-valid cycle.
        vld_d[0]  = run;
        clr_d[0]  = run && tap_first;
        last_d[0] = run && tap_last;
        for (int i = 1; i < L; i++) begin
            vld_d[i]  = vld_q[i-1];
            clr_d[i]  = clr_q[i-1];
            last_d[i] = last_q[i-1];
        end

        wr_d = vld_q[L-1] && last_q[L-1];
        if (wr_d) begin
            waddr_d  = wr_cnt_q;
            wr_cnt_d = wr_cnt_q + 7'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            kc_q     <= '0;
            kr_q     <= '0;
            ch_q     <= '0;
            ocol_q   <= '0;
            orow_q   <= '0;
            vld_q    <= '0;
            clr_q    <= '0;
            last_q   <= '0;
            wr_q     <= 1'b0;
            waddr_q  <= '0;
            wr_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            kc_q     <= kc_d;
            kr_q     <= kr_d;
            ch_q     <= ch_d;
            ocol_q   <= ocol_d;
            orow_q   <= orow_d;
            vld_q    <= vld_d;
            clr_q    <= clr_d;
            last_q   <= last_d;
            wr_q     <= wr_d;
            waddr_q  <= waddr_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    conv2_addr_gen u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .ch       (ch_q),
        .kr       (kr_q),
        .kc       (kc_q),
        .orow     (orow_q),
        .ocol     (ocol_q),
        .f3_raddr (f3_raddr),
        .w_raddr  (w_raddr)
    );

    assign mac_en     = vld_q[L-1];
    assign mac_clr    = vld_q[L-1] && clr_q[L-1];
    assign f4_wr_en   = wr_q;
    assign f4_waddr   = waddr_q;
    assign conv2_done = (state_q == ST_DONE);
    assign busy       = (state_q != ST_IDLE);
endmodule

// File: tb/tb_conv2_ctrl.sv
// Bench for conv2_ctrl: tap-index model checked every cycle plus literal timing/address points.
// Works with CONV2_ADDR_PIPE_EN defined or undefined.
`timescale 1ns/1ps
module tb_conv2_ctrl;
`ifdef CONV2_ADDR_PIPE_EN
    localparam int A = 3;
`else
    localparam int A = 1;
`endif
    localparam int IN_CH = 6;
    localparam int L     = A + 1;
    localparam int TAPS  = IN_CH * 25 * 100;
    localparam int SH    = 3 - A;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        conv2_start = 1'b0;
    logic [10:0] f3_raddr;
    logic [7:0]  w_raddr;
    logic        mac_clr, mac_en, f4_wr_en, conv2_done, busy;
    logic [6:0]  f4_waddr;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    int rs = -1;
    bit chk_on = 1'b0;
    int cnt_mac = 0, cnt_clr = 0, cnt_wr = 0, cnt_done = 0;
    int s;
    int d, ka, km, m;
    bit mac_x, clr_x, wr_x, done_x, busy_x;

    conv2_ctrl #(.IN_CH(IN_CH), .RAM_LAT(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .conv2_start (conv2_start),
        .f3_raddr    (f3_raddr),
        .w_raddr     (w_raddr),
        .mac_clr     (mac_clr),
        .mac_en      (mac_en),
        .f4_waddr    (f4_waddr),
        .f4_wr_en    (f4_wr_en),
        .conv2_done  (conv2_done),
        .busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mac_en"}, mac_en, 0);
        check({tag, "_mac_clr"}, mac_clr, 0);
        check({tag, "_f4_wr_en"}, f4_wr_en, 0);
        check({tag, "_done"}, conv2_done, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_f3_raddr"}, f3_raddr, 0);
        check({tag, "_w_raddr"}, w_raddr, 0);
        check({tag, "_f4_waddr"}, f4_waddr, 0);
    endtask

    task automatic wait_neg(input int t);
        do @(negedge clk); while (cyc < t);
    endtask

    task automatic go_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Model: tap k of a run started in cycle rs is taken in cycle rs+1+k.
    always @(negedge clk) begin
        if (chk_on) begin
            mac_x = 0; clr_x = 0; wr_x = 0; done_x = 0; busy_x = 0;
            if (rs >= 0) begin
                d = cyc - rs;
                busy_x = (d >= 1) && (d <= TAPS + L + 2);
                done_x = (d == TAPS + L + 2);
                km = d - 1 - L;
                if (km >= 0 && km < TAPS) begin
                    mac_x = 1;
                    clr_x = (km % (25 * IN_CH) == 0);
                end
                m = d - 2 - L;
                if (m >= 0 && m < TAPS && (m % (25 * IN_CH)) == 25 * IN_CH - 1) begin
                    wr_x = 1;
                    check("f4_waddr", f4_waddr, m / (25 * IN_CH));
                end
                ka = d - 1 - A;
                if (ka >= 0 && ka < TAPS) begin
                    check("f3_raddr", f3_raddr,
                          ((ka / 25) % IN_CH) * 196 + ((ka / (25 * IN_CH * 10)) + (ka / 5) % 5) * 14
                          + ((ka / (25 * IN_CH)) % 10) + ka % 5);
                    check("w_raddr", w_raddr, ((ka / 25) % IN_CH) * 25 + ((ka / 5) % 5) * 5 + ka % 5);
                end
            end
            check("mac_en", mac_en, mac_x);
            check("mac_clr", mac_clr, clr_x);
            check("f4_wr_en", f4_wr_en, wr_x);
            check("conv2_done", conv2_done, done_x);
            check("busy", busy, busy_x);
            if (mac_en)     cnt_mac++;
            if (mac_clr)    cnt_clr++;
            if (f4_wr_en)   cnt_wr++;
            if (conv2_done) cnt_done++;
            if (rst) begin
                rs = -1;
            end else if (conv2_start && !busy_x) begin
                rs = cyc;
                cnt_mac = 0; cnt_clr = 0; cnt_wr = 0; cnt_done = 0;
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_on = 1'b1;
        wait_neg(cyc);
        check_all_zero("reset");
        go_cyc(cyc + 1);
        rst = 1'b0;
        go_cyc(cyc + 2);

        // Run 1 with an extra start mid-RUN that must be ignored.
        s = cyc;
        conv2_start = 1'b1;
        go_cyc(s + 1);
        conv2_start = 1'b0;
        wait_neg(s + 4 - SH);
        check("first_f3_raddr", f3_raddr, 0);
        check("pre_mac_en", mac_en, 0);
        wait_neg(s + 5 - SH);
        check("first_mac_en", mac_en, 1);
        check("first_mac_clr", mac_clr, 1);
        go_cyc(s + 21);
        conv2_start = 1'b1;
        go_cyc(s + 22);
        conv2_start = 1'b0;
        wait_neg(s + 154 - SH);
        check("pre_wr_en", f4_wr_en, 0);
        wait_neg(s + 155 - SH);
        check("first_wr_en", f4_wr_en, 1);
        check("first_waddr", f4_waddr, 0);
        wait_neg(s + 15003 - SH);
        check("last_tap_f3", f3_raddr, 1175);
        check("last_tap_w", w_raddr, 149);
        wait_neg(s + 15005 - SH);
        check("last_wr_en", f4_wr_en, 1);
        check("last_waddr", f4_waddr, 99);
        wait_neg(s + 15006 - SH);
        check("run1_done", conv2_done, 1);
        wait_neg(s + 15008 - SH);
        check("run1_busy_after", busy, 0);
        check("run1_mac_count", cnt_mac, 15000);
        check("run1_clr_count", cnt_clr, 100);
        check("run1_wr_count", cnt_wr, 100);
        check("run1_done_count", cnt_done, 1);

        // Run 2 aborted by reset at RUN cycle 7000, then immediately restarted.
        go_cyc(cyc + 3);
        s = cyc;
        conv2_start = 1'b1;
        go_cyc(s + 1);
        conv2_start = 1'b0;
        go_cyc(s + 7000);
        rst = 1'b1;
        go_cyc(s + 7001);
        rst = 1'b0;
        conv2_start = 1'b1;
        wait_neg(s + 7001);
        check_all_zero("abort");
        go_cyc(s + 7002);
        conv2_start = 1'b0;
        s = s + 7001;
        wait_neg(s + 15006 - SH);
        check("run3_done", conv2_done, 1);
        wait_neg(s + 15008 - SH);
        check("run3_busy_after", busy, 0);
        check("run3_mac_count", cnt_mac, 15000);
        check("run3_clr_count", cnt_clr, 100);
        check("run3_wr_count", cnt_wr, 100);
        check("run3_done_count", cnt_done, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
